uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clk cycles per serial bit; legal range 1..65535.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  transmit request, sampled each posedge; driven from CPU OI strobe.
REQ-005 data  input  8  byte to send, sampled only on an accepted start.
REQ-006 busy  output  1  frame in progress; CPU controller stalls the OUT instruction while high.
REQ-007 done  output  1  one-cycle pulse marking frame completion.
REQ-008 tx  output  1  serial line, idle high.

Function
REQ-009 Frame format SHALL be 8N1: start bit 0, data[0] first through data[7], one stop bit 1.
REQ-010 States SHALL be IDLE, START, DATA, STOP; every output SHALL be registered.
REQ-011 IDLE: tx=1, busy=0; start=1 at edge N SHALL latch data into a shift register and enter START.
REQ-012 Data input need not be held after edge N; later changes SHALL NOT affect the frame.
REQ-013 After edge N: tx=0, busy=1 for exactly CLKS_PER_BIT cycles (START).
REQ-014 DATA: bit i SHALL drive tx from edge N+CLKS_PER_BIT*(1+i) for CLKS_PER_BIT cycles, i=0..7.
REQ-015 STOP: tx=1 from edge N+9*CLKS_PER_BIT for CLKS_PER_BIT cycles, busy still 1.
REQ-016 At edge N+10*CLKS_PER_BIT: state IDLE, busy=0, done=1 for exactly one cycle.
REQ-017 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles from acceptance to busy falling.
REQ-018 Bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap; width $clog2(CLKS_PER_BIT+1), minimum 1 bit.
REQ-019 Bit index counter SHALL be 3 bits, advancing 0..7 in DATA only; no wrap beyond 7.
REQ-020 start while busy=1 SHALL be ignored, with no queuing and no effect on the current frame.
REQ-021 start during the done cycle SHALL be accepted, giving a back-to-back frame with no idle bit between frames.
REQ-022 start held high continuously SHALL produce consecutive frames, each latching data at its acceptance edge.
REQ-023 done SHALL NOT assert except at frame completion; a frame aborted by rst SHALL NOT produce done.
REQ-024 CLKS_PER_BIT=1 SHALL yield one cycle per bit with identical state sequence.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE, tx=1, busy=0, done=0, and clear both counters and the shift register.
REQ-026 rst SHALL override start in the same cycle; no frame is accepted.
REQ-027 rst mid-frame SHALL abort immediately; the next edge with rst=0, start=1 SHALL begin a fresh frame.

Verification
REQ-028 CLKS_PER_BIT=4, start=1 with data=8'hA5 at edge 0 -> tx per 4-cycle slot 0,1,0,1,0,0,1,0,1,1; busy high over edges 0..39; done=1 after edge 40 only.
REQ-029 During the 8'hA5 frame, pulse start with data=8'hFF at cycle 12 -> waveform unchanged, no second frame.
REQ-030 start held high, data=8'h01 then 8'h80 at the done cycle -> second frame starts at edge 40 with tx=0; slots read 0,1,0,0,0,0,0,0,0,1 then 0,0,0,0,0,0,0,0,1,1; busy stays high across the boundary.
REQ-031 rst=1 at cycle 17 of an 8'h3C frame -> tx=1, busy=0 after that edge; done never pulses; new 8'h55 frame then sends cleanly.
REQ-032 CLKS_PER_BIT=1, data=8'h00 -> tx 0 for 9 cycles then 1; busy high exactly 10 cycles; done at cycle 10.
REQ-033 rst=1 and start=1 on the same edge -> busy stays 0 and tx stays 1.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx -- 8N1 serial transmitter with registered outputs.
//
// Sends one byte per accepted request, least significant bit first, framed by
// one start bit (0) and one stop bit (1). Each serial bit lasts CLKS_PER_BIT
// clock cycles.
//
// Ports:
//   clk    in   system clock; all state changes on its rising edge
//   rst    in   synchronous active-high reset
//   start  in   transmit request, sampled every rising edge
//   data   in   byte to send, captured only when a request is accepted
//   busy   out  high while a frame is in progress
//   done   out  one-cycle pulse after the stop bit completes
//   tx     out  serial line, idles high
module uart_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int CNT_RAW = $clog2(CLKS_PER_BIT + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [2:0]       r_idx,   w_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_tx,    w_tx_nxt;
  logic             r_busy,  w_busy_nxt;
  logic             r_done,  w_done_nxt;
  logic             w_bit_end;

  assign w_bit_end = (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        w_cnt_nxt  = '0;
        w_idx_nxt  = '0;
        if (start) begin
          w_state_nxt = START;
          w_shift_nxt = data;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end

      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_idx == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            // Shift is consumed from bit 0; the next bit to present is bit 1.
            w_idx_nxt   = r_idx + 3'd1;
            w_tx_nxt    = r_shift[1];
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (w_bit_end) begin
          w_done_nxt = 1'b1;
          w_cnt_nxt  = '0;
          w_idx_nxt  = '0;
          // A request on the completion edge chains straight into the next
          // frame, so busy never drops and no idle bit is inserted.
          if (start) begin
            w_state_nxt = START;
            w_shift_nxt = data;
            w_tx_nxt    = 1'b0;
            w_busy_nxt  = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
            w_busy_nxt  = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx.
//
// Two instances run side by side: CLKS_PER_BIT=4 (index 0) and
// CLKS_PER_BIT=1 (index 1). A frame-level reference model predicts tx, busy
// and done after every edge; directed scenarios add hand-derived checks.
module tb_uart_tx;

  logic       clk;
  logic       rs     [2];
  logic       st     [2];
  logic [7:0] dt     [2];
  logic       tx_o   [2];
  logic       busy_o [2];
  logic       done_o [2];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: whether a frame is active, cycles since its acceptance
  // edge, the 10-bit frame (stop, data, start) and the expected done pulse.
  logic       m_act   [2];
  int         m_t     [2];
  logic [9:0] m_frame [2];
  logic       m_done  [2];

  uart_tx #(.CLKS_PER_BIT(4)) u_c4 (
    .clk(clk), .rst(rs[0]), .start(st[0]), .data(dt[0]),
    .busy(busy_o[0]), .done(done_o[0]), .tx(tx_o[0])
  );

  uart_tx #(.CLKS_PER_BIT(1)) u_c1 (
    .clk(clk), .rst(rs[1]), .start(st[1]), .data(dt[1]),
    .busy(busy_o[1]), .done(done_o[1]), .tx(tx_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cpb(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_step(input int i);
    logic fin;
    if (rs[i]) begin
      m_act[i]  = 1'b0;
      m_t[i]    = 0;
      m_done[i] = 1'b0;
    end else begin
      fin       = m_act[i] && (m_t[i] + 1 == 10 * cpb(i));
      m_done[i] = fin;
      if ((!m_act[i] || fin) && st[i]) begin
        m_act[i]   = 1'b1;
        m_t[i]     = 0;
        m_frame[i] = {1'b1, dt[i], 1'b0};
      end else if (m_act[i]) begin
        if (fin) m_act[i] = 1'b0;
        else     m_t[i]   = m_t[i] + 1;
      end
    end
  endtask

  // One clock edge: advance the model on the inputs present at the edge,
  // then compare both instances 1 time unit later.
  task automatic cyc();
    logic etx;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      etx = m_act[i] ? m_frame[i][m_t[i] / cpb(i)] : 1'b1;
      chk((i == 0) ? "tx_c4"   : "tx_c1",   {31'd0, tx_o[i]},   {31'd0, etx});
      chk((i == 0) ? "busy_c4" : "busy_c1", {31'd0, busy_o[i]}, {31'd0, m_act[i]});
      chk((i == 0) ? "done_c4" : "done_c1", {31'd0, done_o[i]}, {31'd0, m_done[i]});
    end
  endtask

  task automatic idle(input int n);
    st[0] = 1'b0;
    st[1] = 1'b0;
    repeat (n) cyc();
  endtask

  initial begin
    logic [9:0]  cap;
    logic [19:0] cap2;
    int nb, nd, de;

    for (int i = 0; i < 2; i++) begin
      rs[i] = 1'b1; st[i] = 1'b0; dt[i] = 8'h00;
      m_act[i] = 1'b0; m_t[i] = 0; m_frame[i] = '1; m_done[i] = 1'b0;
    end
    cyc();
    cyc();
    chk("reset_tx",   {31'd0, tx_o[0]},   32'd1);
    chk("reset_busy", {31'd0, busy_o[0]}, 32'd0);
    chk("reset_done", {31'd0, done_o[0]}, 32'd0);
    rs[0] = 1'b0;
    rs[1] = 1'b0;
    idle(3);

    // 8'hA5 frame with an ignored 8'hFF request at cycle 12; data changes
    // after acceptance must not leak into the frame.
    cap = '0; nb = 0; nd = 0; de = -1;
    for (int e = 0; e < 46; e++) begin
      st[0] = (e == 0) || (e == 12);
      dt[0] = (e == 0) ? 8'hA5 : (e == 12) ? 8'hFF : 8'($urandom);
      cyc();
      if ((e % 4 == 1) && (e < 40)) cap[e / 4] = tx_o[0];
      if (e < 40 && busy_o[0]) nb++;
      if (done_o[0]) begin nd++; de = e; end
    end
    chk("a5_slots",     {22'd0, cap}, 32'h34A);
    chk("a5_busy_cyc",  nb, 32'd40);
    chk("a5_done_cnt",  nd, 32'd1);
    chk("a5_done_edge", de, 32'd40);
    idle(4);

    // start held high: 8'h01 frame, then 8'h80 taken on the completion edge.
    cap2 = '0; nb = 0;
    for (int e = 0; e < 90; e++) begin
      st[0] = (e < 80);
      dt[0] = (e < 40) ? 8'h01 : 8'h80;
      cyc();
      if ((e % 4 == 1) && (e < 80)) cap2[e / 4] = tx_o[0];
      if (e < 80 && busy_o[0]) nb++;
      if (e == 40) chk("b2b_tx_e40", {31'd0, tx_o[0]}, 32'd0);
    end
    chk("b2b_slots",    {12'd0, cap2}, 32'hC0202);
    chk("b2b_busy_cyc", nb, 32'd80);
    idle(4);

    // Reset mid-frame at cycle 17 of an 8'h3C frame.
    for (int e = 0; e < 18; e++) begin
      st[0] = (e == 0);
      dt[0] = 8'h3C;
      rs[0] = (e == 17);
      cyc();
    end
    chk("abort_tx",   {31'd0, tx_o[0]},   32'd1);
    chk("abort_busy", {31'd0, busy_o[0]}, 32'd0);
    rs[0] = 1'b0;
    nd = 0;
    for (int e = 0; e < 50; e++) begin
      st[0] = 1'b0;
      cyc();
      if (done_o[0]) nd++;
    end
    chk("abort_no_done", nd, 32'd0);
    cap = '0; nd = 0;
    for (int e = 0; e < 46; e++) begin
      st[0] = (e == 0);
      dt[0] = 8'h55;
      cyc();
      if ((e % 4 == 1) && (e < 40)) cap[e / 4] = tx_o[0];
      if (done_o[0]) nd++;
    end
    chk("x55_slots",    {22'd0, cap}, 32'h2AA);
    chk("x55_done_cnt", nd, 32'd1);

    // Reset and start on the same edge.
    rs[0] = 1'b1; st[0] = 1'b1; dt[0] = 8'h5A;
    cyc();
    chk("rststart_busy", {31'd0, busy_o[0]}, 32'd0);
    chk("rststart_tx",   {31'd0, tx_o[0]},   32'd1);
    rs[0] = 1'b0; st[0] = 1'b0;
    cyc();
    chk("rststart_busy2", {31'd0, busy_o[0]}, 32'd0);
    idle(2);

    // One cycle per bit, 8'h00.
    cap = '0; nb = 0; nd = 0; de = -1;
    for (int e = 0; e < 16; e++) begin
      st[1] = (e == 0);
      dt[1] = 8'h00;
      cyc();
      if (e < 10) cap[e] = tx_o[1];
      if (busy_o[1]) nb++;
      if (done_o[1]) begin nd++; de = e; end
    end
    chk("c1_slots",     {22'd0, cap}, 32'h200);
    chk("c1_busy_cyc",  nb, 32'd10);
    chk("c1_done_cnt",  nd, 32'd1);
    chk("c1_done_edge", de, 32'd10);

    // Random requests, data and occasional resets on both instances.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        st[i] = ($urandom_range(0, 3) == 0);
        dt[i] = 8'($urandom);
        rs[i] = ($urandom_range(0, 199) == 0);
      end
      cyc();
    end
    rs[0] = 1'b0;
    rs[1] = 1'b0;
    idle(50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
